// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store sizes, LSU state encoding and
// the default bus timeout.
package riscv_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam int LSU_TIMEOUT_CYCLES = 255;

  // Legal size encoding with natural alignment; anything else traps.
  function automatic logic lsu_access_ok(input logic [2:0] funct3, input logic [1:0] offset);
    logic ok;
    case (funct3)
      LS_B, LS_BU: ok = 1'b1;
      LS_H, LS_HU: ok = ~offset[0];
      LS_W:        ok = (offset == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane select/extension for loads.
// Purely combinational.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << {offset[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  always_comb begin
    rbyte = rdata[7:0];
    case (offset)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      LS_B:    load_data = {{24{rbyte[7]}}, rbyte};
      LS_BU:   load_data = {24'd0, rbyte};
      LS_H:    load_data = {{16{rhalf[15]}}, rhalf};
      LS_HU:   load_data = {16'd0, rhalf};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single outstanding bus access per MEM-stage
// instruction, with pipeline stall, timeout and exception pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a legal access in MEM; stall driven combinationally
// REQ      | bus_req high, request fields frozen until bus_gnt
// RSP      | waiting for bus_rvalid (rdata/err captured on it)
// DONE     | one cycle: load_valid or bus_exc, stall released
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        flush_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign_exc,
  output logic        bus_exc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic          flush_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          tout_q;

  logic          access_ok;
  logic          launch;
  logic          tout_hit;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_ldata;
  logic          deliver;

  assign access_ok = lsu_access_ok(funct3_m, addr_m[1:0]);
  assign launch    = (state_q == LSU_IDLE) && mem_en_m && !flush_m && access_ok;
  assign tout_hit  = (cnt_q >= TLIM);

  lsu_align u_align (
    .funct3     (f3_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (rdata_q),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .load_data  (al_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (launch) state_d = LSU_REQ;
      LSU_REQ: begin
        // gnt wins over a same-cycle rvalid and over the last timeout cycle
        if (bus_gnt)       state_d = LSU_RSP;
        else if (tout_hit) state_d = LSU_DONE;
      end
      LSU_RSP: begin
        if (bus_rvalid)    state_d = LSU_DONE;
        else if (tout_hit) state_d = LSU_DONE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      flush_q <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (launch) begin
            cnt_q   <= '0;
            flush_q <= 1'b0;
            we_q    <= mem_write_m;
            f3_q    <= funct3_m;
            addr_q  <= addr_m;
            wdata_q <= wdata_m;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
          end
        end
        LSU_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (flush_m) flush_q <= 1'b1;
          if (!bus_gnt && tout_hit) tout_q <= 1'b1;
        end
        LSU_RSP: begin
          cnt_q <= cnt_q + 1'b1;
          if (flush_m) flush_q <= 1'b1;
          if (bus_rvalid) begin
            rdata_q <= bus_rdata;
            err_q   <= bus_err;
          end else if (tout_hit) begin
            tout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign deliver = !we_q && !err_q && !tout_q && !flush_q;

  always_comb begin
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = 32'd0;
    bus_wdata    = 32'd0;
    bus_be       = 4'b0000;
    stall        = 1'b0;
    load_valid   = 1'b0;
    load_data    = 32'd0;
    misalign_exc = 1'b0;
    bus_exc      = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        // IDLE outputs follow live inputs, so hold them quiet during reset
        if (rst_n && mem_en_m && !flush_m) begin
          if (access_ok) stall = 1'b1;
          else           misalign_exc = 1'b1;
        end
      end
      LSU_REQ: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_be    = al_be;
        bus_wdata = we_q ? al_wdata : 32'd0;
      end
      LSU_RSP: stall = 1'b1;
      default: begin
        load_valid = deliver;
        load_data  = deliver ? al_ldata : 32'd0;
        bus_exc    = (err_q || tout_q) && !flush_q;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: driver pushes expected requests/completions,
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_lsu_ctrl;

  localparam int T = 255;

  logic        clk;
  logic        rst_n;
  logic        mem_en_m;
  logic        mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        flush_m;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign_exc;
  logic        bus_exc;

  lsu_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_en_m     (mem_en_m),
    .mem_write_m  (mem_write_m),
    .funct3_m     (funct3_m),
    .addr_m       (addr_m),
    .wdata_m      (wdata_m),
    .flush_m      (flush_m),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_err      (bus_err),
    .bus_rdata    (bus_rdata),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .misalign_exc (misalign_exc),
    .bus_exc      (bus_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        bexc;
    logic        mexc;
    int          stalls;
  } cpl_t;

  req_t req_q[$];
  cpl_t cpl_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return (a % 2) == 0;
      3'b010:         return (a % 4) == 0;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (int'(a[1:0]) * 8)) & 32'hFF;
    h = (w >> (int'(a[1]) * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic req_t mk_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.addr = a & 32'hFFFFFFFC;
    r.we   = we;
    case (f3[1:0])
      2'b00: begin r.be = 4'(1 << a[1:0]);     r.wdata = (wd & 32'hFF) * 32'h01010101; end
      2'b01: begin r.be = 4'(3 << (a[1] * 2)); r.wdata = (wd & 32'hFFFF) * 32'h00010001; end
      default: begin r.be = 4'hF;              r.wdata = wd; end
    endcase
    return r;
  endfunction

  // gd/rdl: idle cycles before gnt/rvalid, -1 = never; fl: busy-cycle index carrying flush_m
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rword, input logic err,
                         input int gd, input int rdl, input int fl);
    cpl_t c;
    int   n;
    bit   timeout, flushed, rsp, done;
    int   k;
    mem_en_m = 1'b1; mem_write_m = we; funct3_m = f3; addr_m = a; wdata_m = wd; flush_m = 1'b0;
    if (!legal(f3, a)) begin
      c.lv = 0; c.ld = 0; c.bexc = 0; c.mexc = 1; c.stalls = 0;
      cpl_q.push_back(c);
      @(posedge clk); #1;
      mem_en_m = 1'b0;
      return;
    end
    req_q.push_back(mk_req(we, f3, a, wd));
    timeout = (gd < 0) || (rdl < 0);
    n       = timeout ? T : gd + rdl + 2;
    flushed = (fl >= 1) && (fl <= n);
    c.mexc   = 0;
    c.stalls = 1 + n;
    c.bexc   = (timeout || err) && !flushed;
    c.lv     = !we && !timeout && !err && !flushed;
    c.ld     = ext(f3, a, rword);
    cpl_q.push_back(c);

    @(posedge clk); #1;
    rsp = 0; done = 0; k = 0;
    for (int i = 1; i <= T && !done; i++) begin
      flush_m    = (i == fl);
      bus_rdata  = $urandom;
      bus_err    = 1'($urandom_range(0, 1));
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      if (!rsp) begin
        bus_gnt    = (gd >= 0) && (k == gd);
        bus_rvalid = ($urandom_range(0, 3) == 0);
        if (bus_gnt) begin rsp = 1; k = 0; end
        else k++;
      end else begin
        if (rdl >= 0 && k == rdl) begin
          bus_rvalid = 1'b1; bus_rdata = rword; bus_err = err; done = 1;
        end
        k++;
      end
      @(posedge clk); #1;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; flush_m = 1'b0;
    @(posedge clk); #1;
    mem_en_m = 1'b0;
  endtask

  initial begin : monitor
    bit   prev_stall, prev_req;
    int   stall_cnt;
    req_t cur, r;
    cpl_t c;
    prev_stall = 0; prev_req = 0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0; prev_req = 0; stall_cnt = 0;
      end else begin
        if (stall) stall_cnt++;
        if (bus_req) begin
          if (!prev_req) begin
            if (req_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_req got addr=%h want none t=%0t", bus_addr, $time);
            end else begin
              r = req_q.pop_front();
              chk("req_addr", bus_addr, r.addr);
              chk("req_we", 32'(bus_we), 32'(r.we));
              if (r.we) begin
                chk("req_be", 32'(bus_be), 32'(r.be));
                chk("req_wdata", bus_wdata, r.wdata);
              end
            end
            cur.addr = bus_addr; cur.we = bus_we; cur.be = bus_be; cur.wdata = bus_wdata;
          end else begin
            chk("hold_addr", bus_addr, cur.addr);
            chk("hold_we", 32'(bus_we), 32'(cur.we));
            chk("hold_be", 32'(bus_be), 32'(cur.be));
            chk("hold_wdata", bus_wdata, cur.wdata);
          end
        end
        if (misalign_exc || load_valid || bus_exc || (prev_stall && !stall)) begin
          if (cpl_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cpl got lv=%b bexc=%b mexc=%b want none t=%0t",
                     load_valid, bus_exc, misalign_exc, $time);
          end else begin
            c = cpl_q.pop_front();
            chk("load_valid", 32'(load_valid), 32'(c.lv));
            chk("bus_exc", 32'(bus_exc), 32'(c.bexc));
            chk("misalign_exc", 32'(misalign_exc), 32'(c.mexc));
            chk("stall_cycles", 32'(stall_cnt), 32'(c.stalls));
            if (c.lv) chk("load_data", load_data, c.ld);
          end
          stall_cnt = 0;
        end
        prev_stall = stall; prev_req = bus_req;
      end
    end
  end

  initial begin : driver
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          gd, rdl, fl;
    rst_n = 1'b0; mem_en_m = 1'b1; mem_write_m = 1'b0; funct3_m = 3'b010;
    addr_m = 32'h100; wdata_m = 32'd0; flush_m = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
    #12;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_outs", {26'd0, load_valid, bus_exc, misalign_exc, bus_we, 2'b00}, 0);
    chk("rst_addr", bus_addr, 0);
    mem_en_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, -1);
    run_txn(0, 3'b000, 32'h103, 0, 32'h80FFFFFF, 0, 0, 0, -1);
    run_txn(0, 3'b100, 32'h103, 0, 32'h80FFFFFF, 0, 0, 0, -1);
    run_txn(1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 0, -1);
    run_txn(0, 3'b010, 32'h101, 0, 32'h0, 0, 0, 0, -1);
    run_txn(0, 3'b010, 32'h200, 0, 32'h11112222, 1, 3, 0, -1);
    run_txn(0, 3'b010, 32'h204, 0, 32'h0, 0, 0, -1, -1);
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    run_txn(0, 3'b010, 32'h208, 0, 32'h55667788, 0, 0, 2, 2);
    run_txn(1, 3'b010, 32'h20C, 32'hA5A5A5A5, 32'h0, 0, -1, 0, -1);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        mem_en_m = 1'b1; mem_write_m = 1'b0; funct3_m = 3'b010;
        addr_m = 32'h300; flush_m = 1'b1;
        @(posedge clk); #1;
        mem_en_m = 1'b0; flush_m = 1'b0;
        continue;
      end
      we  = 1'($urandom_range(0, 1));
      f3  = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a   = $urandom;
      gd  = $urandom_range(0, 3);
      rdl = $urandom_range(0, 3);
      fl  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, gd + rdl + 2) : -1;
      run_txn(we, f3, a, $urandom, $urandom, ($urandom_range(0, 7) == 0), gd, rdl, fl);
    end

    mem_en_m = 1'b1; mem_write_m = 1'b0; funct3_m = 3'b010; addr_m = 32'h400; flush_m = 1'b0;
    req_q.push_back(mk_req(0, 3'b010, 32'h400, 0));
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(stall), 0);
    chk("rst_mid_req", 32'(bus_req), 0);
    chk("rst_mid_outs", {27'd0, load_valid, bus_exc, misalign_exc, bus_we, 1'b0}, 0);
    chk("rst_mid_ldata", load_data, 0);
    @(posedge clk); #1;
    mem_en_m = 1'b0;
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    chk("cpl_q_drained", 32'(cpl_q.size()), 0);
    chk("req_q_drained", 32'(req_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
